// File: rtl/cmu_theta44_if.sv
// Request/result bundle for cmu_theta44: start + operands in, Theta_10_10/valid_out/busy out.
interface cmu_theta44_if #(
  parameter int unsigned DBL_WIDTH = 64
);
  logic                 start;
  logic [DBL_WIDTH-1:0] dt;
  logic [DBL_WIDTH-1:0] P_10_10;
  logic [DBL_WIDTH-1:0] P_10_13;
  logic [DBL_WIDTH-1:0] P_13_13;
  logic [DBL_WIDTH-1:0] Theta_10_10;
  logic                 valid_out;
  logic                 busy;

  modport master (
    output start, dt, P_10_10, P_10_13, P_13_13,
    input  Theta_10_10, valid_out, busy
  );

  modport slave (
    input  start, dt, P_10_10, P_10_13, P_13_13,
    output Theta_10_10, valid_out, busy
  );
endinterface

// File: rtl/cmu_theta44.sv
// Theta_10_10 = P_10_10 + dt*(2*P_10_13 + dt*P_13_13), serialised over one FP multiplier and adder.
// Optional macro CMU_THETA44_CLAMP_EN: negative non-NaN results are forced to +0.0.

// Double multiplier, round-to-nearest-even, subnormals flushed to zero; one-cycle latency.
module fp_multiplier (
  input  logic        clk,
  input  logic        valid,
  output logic        finish,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  localparam int unsigned PW = 106;
  localparam logic [63:0] QNAN = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] QBIT = 64'h0008_0000_0000_0000;

  logic [PW-1:0] w_p;
  logic [52:0]   w_m53;
  logic [53:0]   w_m;
  logic [13:0]   w_e;
  logic          w_g, w_st, w_up, w_s;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [63:0]   w_res;

  assign w_a_nan  = (a[62:52] == 11'h7ff) && (a[51:0] != 52'd0);
  assign w_b_nan  = (b[62:52] == 11'h7ff) && (b[51:0] != 52'd0);
  assign w_a_inf  = (a[62:52] == 11'h7ff) && (a[51:0] == 52'd0);
  assign w_b_inf  = (b[62:52] == 11'h7ff) && (b[51:0] == 52'd0);
  assign w_a_zero = (a[62:52] == 11'd0);
  assign w_b_zero = (b[62:52] == 11'd0);

  always_comb begin : p_mul
    w_p = PW'({1'b1, a[51:0]}) * PW'({1'b1, b[51:0]});
    if (w_p[105]) begin
      w_m53 = w_p[105:53];
      w_g   = w_p[52];
      w_st  = |w_p[51:0];
    end else begin
      w_m53 = w_p[104:52];
      w_g   = w_p[51];
      w_st  = |w_p[50:0];
    end
    w_up = w_g & (w_st | w_m53[0]);
    w_m  = {1'b0, w_m53} + 54'(w_up);
    w_e  = 14'(a[62:52]) + 14'(b[62:52]) + 14'(w_p[105]) + 14'(w_m[53]);
    w_s  = a[63] ^ b[63];
    if (w_a_nan)                                    w_res = a | QBIT;
    else if (w_b_nan)                               w_res = b | QBIT;
    else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_res = QNAN;
    else if (w_a_inf || w_b_inf)                    w_res = {w_s, 11'h7ff, 52'd0};
    else if (w_a_zero || w_b_zero)                  w_res = {w_s, 63'd0};
    else if (w_e <= 14'd1023)                       w_res = {w_s, 63'd0};
    else if (w_e - 14'd1023 >= 14'd2047)            w_res = {w_s, 11'h7ff, 52'd0};
    else w_res = {w_s, 11'(w_e - 14'd1023), (w_m[53] ? w_m[52:1] : w_m[51:0])};
  end

  // No reset: a late finish after a parent reset is filtered by the FSM.
  always_ff @(posedge clk) begin
    finish <= valid;
    if (valid) result <= w_res;
  end
endmodule

// Double adder, round-to-nearest-even, subnormals flushed to zero; one-cycle latency.
module fp_adder (
  input  logic        clk,
  input  logic        valid,
  output logic        finish,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);
  localparam int unsigned MW = 56;
  localparam logic [63:0] QNAN = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] QBIT = 64'h0008_0000_0000_0000;

  logic [63:0]   w_big, w_sml, w_res;
  logic [10:0]   w_d;
  logic [MW-1:0] w_mbig, w_msml, w_al, w_n;
  logic [MW:0]   w_sum;
  logic [5:0]    w_lz, w_lzv;
  logic          w_sticky, w_up, w_inc;
  logic [53:0]   w_m;
  logic [12:0]   w_e;
  logic          w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_nan  = (a[62:52] == 11'h7ff) && (a[51:0] != 52'd0);
  assign w_b_nan  = (b[62:52] == 11'h7ff) && (b[51:0] != 52'd0);
  assign w_a_inf  = (a[62:52] == 11'h7ff) && (a[51:0] == 52'd0);
  assign w_b_inf  = (b[62:52] == 11'h7ff) && (b[51:0] == 52'd0);
  assign w_a_zero = (a[62:52] == 11'd0);
  assign w_b_zero = (b[62:52] == 11'd0);

  always_comb begin : p_add
    w_big = a;
    w_sml = b;
    if (b[62:0] > a[62:0]) begin
      w_big = b;
      w_sml = a;
    end
    w_d    = w_big[62:52] - w_sml[62:52];
    w_mbig = {1'b1, w_big[51:0], 3'b000};
    w_msml = {1'b1, w_sml[51:0], 3'b000};
    // Alignment keeps guard/round bits plus a sticky OR of everything shifted out.
    if (w_d >= 11'd56) begin
      w_al     = '0;
      w_sticky = 1'b1;
    end else begin
      w_al     = w_msml >> w_d;
      w_sticky = |(w_msml & ~({MW{1'b1}} << w_d));
    end
    w_al[0] = w_al[0] | w_sticky;
    if (w_big[63] ^ w_sml[63]) w_sum = {1'b0, w_mbig} - {1'b0, w_al};
    else                       w_sum = {1'b0, w_mbig} + {1'b0, w_al};
    w_lz = '0;
    for (int i = 0; i < 56; i++) begin
      if (w_sum[i]) w_lz = 6'(55 - i);
    end
    w_inc = w_sum[56];
    w_lzv = w_inc ? 6'd0 : w_lz;
    if (w_inc) w_n = {w_sum[56:2], w_sum[1] | w_sum[0]};
    else       w_n = w_sum[55:0] << w_lz;
    w_up = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
    w_m  = {1'b0, w_n[55:3]} + 54'(w_up);
    w_e  = 13'(w_big[62:52]) + 13'(w_inc) + 13'(w_m[53]);
    if (w_a_nan)                                    w_res = a | QBIT;
    else if (w_b_nan)                               w_res = b | QBIT;
    else if (w_a_inf && w_b_inf && (a[63] != b[63])) w_res = QNAN;
    else if (w_a_inf)                               w_res = a;
    else if (w_b_inf)                               w_res = b;
    else if (w_a_zero && w_b_zero)                  w_res = {a[63] & b[63], 63'd0};
    else if (w_a_zero)                              w_res = b;
    else if (w_b_zero)                              w_res = a;
    else if (w_sum == '0)                           w_res = 64'd0;
    else if (w_e <= 13'(w_lzv))                     w_res = {w_big[63], 63'd0};
    else if (w_e - 13'(w_lzv) >= 13'd2047)          w_res = {w_big[63], 11'h7ff, 52'd0};
    else w_res = {w_big[63], 11'(w_e - 13'(w_lzv)), (w_m[53] ? w_m[52:1] : w_m[51:0])};
  end

  always_ff @(posedge clk) begin
    finish <= valid;
    if (valid) result <= w_res;
  end
endmodule

module cmu_theta44 #(
  parameter int unsigned DBL_WIDTH = 64
) (
  input logic           clk,
  input logic           rst_n,
  cmu_theta44_if.slave  bus
);
  localparam int unsigned DW = DBL_WIDTH;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_M1   = 3'd1;
  localparam logic [2:0] S_A1   = 3'd2;
  localparam logic [2:0] S_A2   = 3'd3;
  localparam logic [2:0] S_M2   = 3'd4;
  localparam logic [2:0] S_A3   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]    r_state, w_state_nxt;
  logic [DW-1:0] r_dt, r_p1010, r_p1013, r_p1313, r_s, r_theta;
  logic [DW-1:0] w_dt_nxt, w_p1010_nxt, w_p1013_nxt, w_p1313_nxt, w_s_nxt, w_theta_nxt;
  logic          r_mul_go, r_add_go, r_valid, r_busy;
  logic          w_mul_go_nxt, w_add_go_nxt, w_valid_nxt, w_busy_nxt;
  logic [DW-1:0] w_mul_a, w_mul_b, w_add_a, w_add_b, w_mul_res, w_add_res, w_th_c;
  logic          w_mul_fin, w_add_fin;

  fp_multiplier u_mul (
    .clk(clk), .valid(r_mul_go), .finish(w_mul_fin),
    .a(w_mul_a), .b(w_mul_b), .result(w_mul_res)
  );

  fp_adder u_add (
    .clk(clk), .valid(r_add_go), .finish(w_add_fin),
    .a(w_add_a), .b(w_add_b), .result(w_add_res)
  );

  // Operand steering held constant for the whole state, so stable from go to finish.
  always_comb begin : p_operands
    w_mul_a = r_dt;
    w_mul_b = (r_state == S_M2) ? r_s : r_p1313;
    w_add_a = (r_state == S_A3) ? r_p1010 : r_s;
    w_add_b = (r_state == S_A3) ? r_s : r_p1013;
  end

  always_comb begin : p_clamp
    w_th_c = w_add_res;
`ifdef CMU_THETA44_CLAMP_EN
    if (w_add_res[DW-1] && !((&w_add_res[DW-2:DW-12]) && (|w_add_res[DW-13:0])))
      w_th_c = '0;
`else
`endif
  end

  always_comb begin : p_fsm
    w_state_nxt  = r_state;
    w_dt_nxt     = r_dt;
    w_p1010_nxt  = r_p1010;
    w_p1013_nxt  = r_p1013;
    w_p1313_nxt  = r_p1313;
    w_s_nxt      = r_s;
    w_theta_nxt  = r_theta;
    w_mul_go_nxt = 1'b0;
    w_add_go_nxt = 1'b0;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_dt_nxt     = bus.dt;
        w_p1010_nxt  = bus.P_10_10;
        w_p1013_nxt  = bus.P_10_13;
        w_p1313_nxt  = bus.P_13_13;
        w_mul_go_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
        w_state_nxt  = S_M1;
      end
      S_M1: if (w_mul_fin) begin
        w_s_nxt      = w_mul_res;
        w_add_go_nxt = 1'b1;
        w_state_nxt  = S_A1;
      end
      S_A1: if (w_add_fin) begin
        w_s_nxt      = w_add_res;
        w_add_go_nxt = 1'b1;
        w_state_nxt  = S_A2;
      end
      S_A2: if (w_add_fin) begin
        w_s_nxt      = w_add_res;
        w_mul_go_nxt = 1'b1;
        w_state_nxt  = S_M2;
      end
      S_M2: if (w_mul_fin) begin
        w_s_nxt      = w_mul_res;
        w_add_go_nxt = 1'b1;
        w_state_nxt  = S_A3;
      end
      S_A3: if (w_add_fin) begin
        w_theta_nxt  = w_th_c;
        w_valid_nxt  = 1'b1;
        w_state_nxt  = S_DONE;
      end
      S_DONE: begin
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_busy_nxt   = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dt     <= '0;
      r_p1010  <= '0;
      r_p1013  <= '0;
      r_p1313  <= '0;
      r_s      <= '0;
      r_theta  <= '0;
      r_mul_go <= 1'b0;
      r_add_go <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dt     <= w_dt_nxt;
      r_p1010  <= w_p1010_nxt;
      r_p1013  <= w_p1013_nxt;
      r_p1313  <= w_p1313_nxt;
      r_s      <= w_s_nxt;
      r_theta  <= w_theta_nxt;
      r_mul_go <= w_mul_go_nxt;
      r_add_go <= w_add_go_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.Theta_10_10 = r_theta;
  assign bus.valid_out   = r_valid;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_cmu_theta44.sv
// Directed plus randomized checks of cmu_theta44 against a real-arithmetic reference model.
module tb_cmu_theta44;
  localparam int MUL_LAT = 1;
  localparam int ADD_LAT = 1;
  localparam int LAT     = 2 * MUL_LAT + 3 * ADD_LAT + 6;
  localparam int LIMIT   = 60;

  localparam logic [63:0] ONE   = 64'h3ff0_0000_0000_0000;
  localparam logic [63:0] HALF  = 64'h3fe0_0000_0000_0000;
  localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE = 64'h4008_0000_0000_0000;
  localparam logic [63:0] FOUR  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] MTWO  = 64'hc000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cmu_theta44_if #(.DBL_WIDTH(64)) bus ();

  cmu_theta44 #(.DBL_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Random normal double with exponent within +/-20 of 1.0.
  function automatic logic [63:0] rnd_dbl();
    logic [63:0] r;
    r[63]    = 1'($urandom_range(0, 1));
    r[62:52] = 11'(1003 + $urandom_range(0, 40));
    r[51:0]  = 52'(rnd64());
    return r;
  endfunction

  // Evaluates the five operations in order with IEEE double rounding at each step.
  function automatic logic [63:0] model(input logic [63:0] d, p10, p13, p33);
    real rd, m, s, th;
    logic [63:0] r;
    rd = $bitstoreal(d);
    m  = rd * $bitstoreal(p33);
    s  = m + $bitstoreal(p13);
    s  = s + $bitstoreal(p13);
    s  = rd * s;
    th = $bitstoreal(p10) + s;
    r  = $realtobits(th);
`ifdef CMU_THETA44_CLAMP_EN
    if (r[63] && !((r[62:52] == 11'h7ff) && (r[51:0] != 52'd0))) r = 64'd0;
`endif
    return r;
  endfunction

  task automatic scramble();
    bus.dt      = rnd64();
    bus.P_10_10 = rnd64();
    bus.P_10_13 = rnd64();
    bus.P_13_13 = rnd64();
  endtask

  // One transaction; optional ignored start mid-run (mid>0) or in the valid_out cycle.
  task automatic run_op(input string tag, input logic [63:0] d, p10, p13, p33,
                        input logic [63:0] exp, input int mid, input bit poke_done);
    int cyc;
    bit seen;
    bus.start   = 1'b1;
    bus.dt      = d;
    bus.P_10_10 = p10;
    bus.P_10_13 = p13;
    bus.P_13_13 = p33;
    tick();
    bus.start = 1'b0;
    scramble();
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= LIMIT) begin
      if (bus.valid_out) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
        if (cyc == mid) begin
          scramble();
          bus.start = 1'b1;
        end
        tick();
        bus.start = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_valid_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(LAT));
    chk({tag, "_theta"}, bus.Theta_10_10, exp);
    chk({tag, "_busy_at_valid"}, 64'(bus.busy), 64'd1);
    if (poke_done) begin
      scramble();
      bus.start = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    chk({tag, "_valid_pulse"}, 64'(bus.valid_out), 64'd0);
    chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    chk({tag, "_theta_hold"}, bus.Theta_10_10, exp);
  endtask

  initial begin : stim
    logic [63:0] d, p10, p13, p33, neg_exp;
    int nvalid;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.dt = '0; bus.P_10_10 = '0; bus.P_10_13 = '0; bus.P_13_13 = '0;
    tick();
    tick();
    chk("rst_theta", bus.Theta_10_10, 64'd0);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("basic", ONE, ONE, HALF, TWO, FOUR, 0, 1'b0);
    run_op("zero_dt", 64'd0, THREE, rnd_dbl(), rnd_dbl(), THREE, 0, 1'b0);
`ifdef CMU_THETA44_CLAMP_EN
    neg_exp = 64'h0000_0000_0000_0000;
`else
    neg_exp = 64'hc008_0000_0000_0000;
`endif
    run_op("negative", ONE, ONE, MTWO, 64'd0, neg_exp, 0, 1'b0);
    run_op("start_busy", ONE, ONE, HALF, TWO, FOUR, 4, 1'b0);
    run_op("start_done", ONE, ONE, HALF, TWO, FOUR, 0, 1'b1);

    // Reset during the second multiply, then a clean run.
    bus.start = 1'b1;
    bus.dt = ONE; bus.P_10_10 = ONE; bus.P_10_13 = HALF; bus.P_13_13 = TWO;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_theta", bus.Theta_10_10, 64'd0);
    chk("midrst_valid", 64'(bus.valid_out), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.valid_out) nvalid++;
    end
    chk("postrst_no_valid", 64'(nvalid), 64'd0);
    chk("postrst_busy", 64'(bus.busy), 64'd0);
    chk("postrst_theta", bus.Theta_10_10, 64'd0);
    run_op("after_rst", ONE, ONE, HALF, TWO, FOUR, 0, 1'b0);

    // Back-to-back: each run_op starts on the cycle after the previous valid_out.
    run_op("b2b", ONE, ONE, HALF, TWO, FOUR, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      d   = (k % 7 == 3) ? 64'd0 : rnd_dbl();
      p10 = rnd_dbl();
      p13 = rnd_dbl();
      p33 = rnd_dbl();
      run_op("rand", d, p10, p13, p33, model(d, p10, p13, p33), (k % 5 == 0) ? 6 : 0, 1'(k % 3 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
